// File: rtl/mux_scan_n_if.sv
// mux_scan_n_if: bundles the channel bus and control/observation signals of
// mux_scan_n.
//   data_in  : N*W packed channels, channel c at [c*W +: W], channel 0 in LSBs
//   mode     : 0 = manual select, 1 = auto-scan
//   sel      : manual channel select (ignored in scan mode)
//   hold     : freezes the scan pointer and dwell counter
//   data_out : registered selected channel data
//   ch_out   : channel index carried by data_out
//   valid    : data_out holds a legal channel's data
//   wrap     : pulse on the final dwell cycle of channel N-1 in scan mode
// Modports: master drives the inputs and observes the outputs; slave is the
// mux side.
interface mux_scan_n_if #(
  parameter int W    = 1,
  parameter int N    = 8,
  parameter int SELW = 3
);
  logic [N*W-1:0]  data_in;
  logic            mode;
  logic [SELW-1:0] sel;
  logic            hold;
  logic [W-1:0]    data_out;
  logic [SELW-1:0] ch_out;
  logic            valid;
  logic            wrap;

  modport master (
    output data_in, mode, sel, hold,
    input  data_out, ch_out, valid, wrap
  );

  modport slave (
    input  data_in, mode, sel, hold,
    output data_out, ch_out, valid, wrap
  );
endinterface

// File: rtl/mux_scan_n.sv
// mux_scan_n: registered N-to-1 multiplexer of W-bit channels with a manual
// select mode and an auto-scan mode that steps a channel pointer through all
// channels, dwelling DWELL cycles on each.
// Ports:
//   clk  : rising-edge clock
//   rst  : synchronous active-high reset, clears outputs, pointer and counter
//   bus  : mux_scan_n_if.slave (data_in, mode, sel, hold -> data_out,
//          ch_out, valid, wrap)
// Output latency is one cycle in both modes.
module mux_scan_n #(
  parameter int W     = 1,
  parameter int N     = 8,
  parameter int SELW  = 3,
  parameter int DWELL = 1
) (
  input  logic          clk,
  input  logic          rst,
  mux_scan_n_if.slave   bus
);

  localparam int CNTW = (DWELL > 1) ? $clog2(DWELL) : 1;
  localparam logic [SELW:0]   NUM_CH   = (SELW+1)'(N);
  localparam logic [SELW-1:0] LAST_CH  = SELW'(N - 1);
  localparam logic [CNTW-1:0] LAST_CNT = CNTW'(DWELL - 1);

  logic [SELW-1:0] ptr_q, ptr_d;
  logic [CNTW-1:0] cnt_q, cnt_d;
  logic [W-1:0]    data_out_q, data_out_d;
  logic [SELW-1:0] ch_out_q, ch_out_d;
  logic            valid_q, valid_d;
  logic            wrap_q, wrap_d;

  logic [SELW-1:0] idx;
  logic [W-1:0]    sel_data;
  logic            in_range;

  // Channel lookup by comparison so an out-of-range index yields zero
  // instead of reading past the end of data_in.
  always_comb begin
    idx      = bus.mode ? ptr_q : bus.sel;
    sel_data = '0;
    for (int c = 0; c < N; c++) begin
      if (idx == SELW'(c)) sel_data = bus.data_in[c*W +: W];
    end
    in_range = ({1'b0, bus.sel} < NUM_CH);
  end

  always_comb begin
    ptr_d      = ptr_q;
    cnt_d      = cnt_q;
    data_out_d = sel_data;
    ch_out_d   = idx;
    valid_d    = 1'b1;
    wrap_d     = 1'b0;
    if (!bus.mode) begin
      // Manual mode parks the scan state so each scan entry starts fresh.
      ptr_d   = '0;
      cnt_d   = '0;
      valid_d = in_range;
    end else if (!bus.hold) begin
      if (cnt_q == LAST_CNT) begin
        cnt_d  = '0;
        ptr_d  = (ptr_q == LAST_CH) ? '0 : ptr_q + SELW'(1);
        wrap_d = (ptr_q == LAST_CH);
      end else begin
        cnt_d = cnt_q + CNTW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q      <= '0;
      cnt_q      <= '0;
      data_out_q <= '0;
      ch_out_q   <= '0;
      valid_q    <= 1'b0;
      wrap_q     <= 1'b0;
    end else begin
      ptr_q      <= ptr_d;
      cnt_q      <= cnt_d;
      data_out_q <= data_out_d;
      ch_out_q   <= ch_out_d;
      valid_q    <= valid_d;
      wrap_q     <= wrap_d;
    end
  end

  assign bus.data_out = data_out_q;
  assign bus.ch_out   = ch_out_q;
  assign bus.valid    = valid_q;
  assign bus.wrap     = wrap_q;

endmodule

// File: doc/mux_scan_n.md
# mux_scan_n

Parametrised, registered N-to-1 multiplexer of W-bit channels with a manual-select mode and an auto-scan mode. In auto-scan, an internal channel pointer steps through all channels, dwelling a programmable number of cycles on each. It serves as the channel selector/serializer for monitoring and time-division readout paths, and replaces the fixed 8-to-1 single-bit combinational mux.

## Interface
- `W`, 1, width of each channel in bits.
- `N`, 8, number of channels (N >= 2).
- `SELW`, 3, select/pointer width; must satisfy 2**SELW >= N.
- `DWELL`, 1, cycles spent on each channel in scan mode (DWELL >= 1).

- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `data_in`  in  N*W  channel c occupies bits [c*W +: W]; channel 0 is in the LSBs.
- `mode`  in  1  0 = manual (`sel` chooses the channel), 1 = auto-scan.
- `sel`  in  SELW  manual channel select; ignored when `mode`=1.
- `hold`  in  1  scan mode only; freezes the pointer and dwell counter.
- `data_out`  out  W  registered selected channel data.
- `ch_out`  out  SELW  channel index that `data_out` currently carries.
- `valid`  out  1  1 when `data_out` holds a legal channel's data.
- `wrap`  out  1  one-cycle pulse marking the final dwell cycle of channel N-1 in scan mode.

## Operation
- Reset (`rst`=1 at an edge) sets `data_out`=0, `ch_out`=0, `valid`=0, `wrap`=0, internal pointer `ptr`=0 and dwell counter `cnt`=0. Reset overrides all other inputs.
- Manual mode (`mode`=0), at each edge:
  - `data_out` <= `data_in[sel*W +: W]`, `ch_out` <= `sel`, `valid` <= 1, `wrap` <= 0.
  - If `sel` >= N: `data_out` <= 0, `ch_out` <= `sel`, `valid` <= 0.
  - `ptr` <= 0 and `cnt` <= 0 every cycle, so each entry into scan mode starts at channel 0 with a fresh dwell.
- Scan mode (`mode`=1), at each edge:
  - `data_out` <= `data_in[ptr*W +: W]`, `ch_out` <= `ptr`, `valid` <= 1.
  - If `hold`=0:
    - When `cnt`=DWELL-1: `cnt` <= 0, and `ptr` <= 0 if `ptr`=N-1, otherwise `ptr` <= `ptr`+1.
    - Otherwise: `cnt` <= `cnt`+1.
  - If `hold`=1: `ptr` and `cnt` are unchanged. Output still resamples `data_in` of the current channel every cycle.
  - `wrap` <= (`hold`=0 and `cnt`=DWELL-1 and `ptr`=N-1).
- `ptr` never takes a value >= N. `cnt` width is clog2(DWELL) bits, with a minimum of 1.
- Switching scan -> manual takes effect at the next edge; the scan position is discarded.

## Timing
- Latency is 1 cycle in both modes: the output after edge k reflects `data_in`/`sel`/`mode` sampled at edge k.
- Scan period is N*DWELL cycles per full sweep; `wrap` fires once per sweep.
- With `hold` asserted for H cycles, the current channel's dwell is extended by exactly H cycles.
- First scan output after `mode` goes 0->1 is channel 0, held for DWELL cycles (unless `hold` is asserted).
- Reset mid-scan: the next output after reset is the reset values. If `mode`=1 after reset, channel 0 appears one cycle after `rst` falls.
- `wrap` is never asserted in manual mode or during reset.

## Test plan
- Manual sweep (W=1, N=8, `data_in`=8'b10011101): drive `sel`=0..7, one value per cycle -> `data_out` = 1,0,1,1,1,0,0,1 one cycle later; `ch_out` tracks `sel`; `valid`=1 throughout.
- Scan sweep (W=1, N=8, DWELL=2, same data): assert `mode`=1 for 20 cycles -> each bit is held 2 cycles in channel order 0..7; `wrap` pulses exactly on cycle 16 of scan (channel 7's second cycle); channel 0 reappears on cycle 17.
- Hold (DWELL=1): assert `hold` for 3 cycles while `ch_out`=3 -> `ch_out` stays 3 for 4 cycles total, then advances to 4; no `wrap` is generated during hold.
- Out-of-range select (N=6, SELW=3): `sel`=7 in manual mode -> `data_out`=0, `valid`=0, `ch_out`=7. Then `sel`=5 -> `valid`=1 with channel 5 data.
- Reset mid-scan (N=8, DWELL=1): pulse `rst` while `ch_out`=5 -> all outputs 0 and `valid`=0 for the reset cycle; scan resumes at channel 0.
- Wide channels (W=4, N=4, `data_in`=16'hA5C3, scan, DWELL=1): `data_out` = 3, C, 5, A repeating; `wrap` fires every 4th cycle.
